// File: rtl/operand_forward_pkg.sv
// operand_forward_pkg
//   Constants and types shared by the operand forwarding datapath and the
//   hazard detector: forwarding codes, opcodes and the interlock FSM states.
package operand_forward_pkg;

  // Forwarding codes produced by the hazard detector
  localparam logic [2:0] FWD_RF    = 3'b000;
  localparam logic [2:0] FWD_EXMEM = 3'b001;
  localparam logic [2:0] FWD_MEMWB = 3'b010;

  // Opcodes the forwarding logic needs to recognise
  localparam logic [5:0] OP_ADD  = 6'b00_0001;
  localparam logic [5:0] OP_ADDI = 6'b10_1100;
  localparam logic [5:0] OP_LW   = 6'b10_0011;

  // Load-use interlock states
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fwd_state_e;

  // True for the codes 011..111, which the detector never legitimately emits
  function automatic logic fwd_reserved(input logic [2:0] code);
    return (code != FWD_RF) && (code != FWD_EXMEM) && (code != FWD_MEMWB);
  endfunction

endpackage

// File: rtl/operand_forward_if.sv
// operand_forward_if
//   Bundles the RF->EX boundary signals of operand_forward.
//   master: pipeline side (drives codes, RF data, EX result, load data)
//   slave : operand_forward (drives operands, valid, stall, error pulse)
interface operand_forward_if #(
  parameter int DW = 32
);
  logic [2:0]    ctrl_s1;
  logic [2:0]    ctrl_s2;
  logic [DW-1:0] rf_s1;
  logic [DW-1:0] rf_s2;
  logic [DW-1:0] alu_result;
  logic [5:0]    ex_op;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] op_s1;
  logic [DW-1:0] op_s2;
  logic          op_valid;
  logic          stall;
  logic          fwd_err;

  modport master (
    output ctrl_s1, ctrl_s2, rf_s1, rf_s2, alu_result, ex_op, mem_rdata,
    input  op_s1, op_s2, op_valid, stall, fwd_err
  );

  modport slave (
    input  ctrl_s1, ctrl_s2, rf_s1, rf_s2, alu_result, ex_op, mem_rdata,
    output op_s1, op_s2, op_valid, stall, fwd_err
  );
endinterface

// File: rtl/operand_forward_fwd_mux.sv
// fwd_mux
//   Combinational operand selector for one ALU source.
//   code    : forwarding code (RF / EX/MEM / MEM/WB / reserved)
//   hold    : interlock second cycle; load data has moved to MEM/WB
//   rf, exmem, memwb, hold_wb : candidate operand values
//   opnd    : selected operand
//   rsv     : code was a reserved value (operand falls back to rf)
module fwd_mux
  import operand_forward_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    code,
  input  logic          hold,
  input  logic [DW-1:0] rf,
  input  logic [DW-1:0] exmem,
  input  logic [DW-1:0] memwb,
  input  logic [DW-1:0] hold_wb,
  output logic [DW-1:0] opnd,
  output logic          rsv
);

  // Source select; during HOLD the pipe has advanced one slot, so EX/MEM
  // requests read MEM/WB and MEM/WB requests read the shadowed old value.
  always_comb begin
    opnd = rf;
    rsv  = fwd_reserved(code);
    case (code)
      FWD_RF: begin
        opnd = rf;
      end
      FWD_EXMEM: begin
        if (hold) opnd = memwb;
        else      opnd = exmem;
      end
      FWD_MEMWB: begin
        if (hold) opnd = hold_wb;
        else      opnd = memwb;
      end
      default: begin
        opnd = rf;
      end
    endcase
  end

endmodule

// File: rtl/operand_forward.sv
// operand_forward
//   Selects each ALU source operand from the register file or the EX/MEM,
//   MEM/WB result copies, and inserts a one-cycle interlock when an EX/MEM
//   forward targets a load whose data only exists at MEM/WB.
//   clk : pipeline clock, rising edge
//   rst : asynchronous active-high reset
//   bus : operand_forward_if.slave (codes, RF data, EX result, load data in;
//         registered operands, op_valid, stall, fwd_err out)
module operand_forward
  import operand_forward_pkg::*;
#(
  parameter int         DW      = 32,
  parameter logic [5:0] LOAD_OP = OP_LW
) (
  input logic              clk,
  input logic              rst,
  operand_forward_if.slave bus
);

  fwd_state_e    state_r;
  fwd_state_e    state_nxt_s;
  logic [DW-1:0] exmem_res_r;
  logic [DW-1:0] memwb_res_r;
  logic [DW-1:0] hold_wb_r;
  logic [DW-1:0] op_s1_r;
  logic [DW-1:0] op_s2_r;
  logic [DW-1:0] sel_s1_s;
  logic [DW-1:0] sel_s2_s;
  logic          exmem_ld_r;
  logic          op_valid_r;
  logic          fwd_err_r;
  logic          rsv_s1_s;
  logic          rsv_s2_s;
  logic          load_use_s;
  logic          stall_s;
  logic          hold_s;

  assign load_use_s = ((bus.ctrl_s1 == FWD_EXMEM) || (bus.ctrl_s2 == FWD_EXMEM)) && exmem_ld_r;

  fwd_mux #(.DW(DW)) u_mux_s1 (
    .code    (bus.ctrl_s1),
    .hold    (hold_s),
    .rf      (bus.rf_s1),
    .exmem   (exmem_res_r),
    .memwb   (memwb_res_r),
    .hold_wb (hold_wb_r),
    .opnd    (sel_s1_s),
    .rsv     (rsv_s1_s)
  );

  fwd_mux #(.DW(DW)) u_mux_s2 (
    .code    (bus.ctrl_s2),
    .hold    (hold_s),
    .rf      (bus.rf_s2),
    .exmem   (exmem_res_r),
    .memwb   (memwb_res_r),
    .hold_wb (hold_wb_r),
    .opnd    (sel_s2_s),
    .rsv     (rsv_s2_s)
  );

  // Interlock next-state and stall decode
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    hold_s      = 1'b0;
    case (state_r)
      RUN: begin
        if (load_use_s) begin
          state_nxt_s = HOLD;
          stall_s     = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HOLD: begin
        hold_s      = 1'b1;
        state_nxt_s = RUN;
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // Interlock state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= RUN;
    else     state_r <= state_nxt_s;
  end

  // Result pipe; it also advances on the stall edge so the load reaches
  // MEM/WB, and the pre-advance MEM/WB value is shadowed for HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem_res_r <= {DW{1'b0}};
      exmem_ld_r  <= 1'b0;
      memwb_res_r <= {DW{1'b0}};
      hold_wb_r   <= {DW{1'b0}};
    end else begin
      exmem_res_r <= bus.alu_result;
      exmem_ld_r  <= (bus.ex_op == LOAD_OP);
      memwb_res_r <= exmem_ld_r ? bus.mem_rdata : exmem_res_r;
      if (stall_s) hold_wb_r <= memwb_res_r;
    end
  end

  // Operand registers and status; reserved codes are reported once per
  // instruction, so the repeat of a frozen code in HOLD is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_s1_r    <= {DW{1'b0}};
      op_s2_r    <= {DW{1'b0}};
      op_valid_r <= 1'b0;
      fwd_err_r  <= 1'b0;
    end else begin
      if (!stall_s) begin
        op_s1_r <= sel_s1_s;
        op_s2_r <= sel_s2_s;
      end
      op_valid_r <= !stall_s;
      fwd_err_r  <= (rsv_s1_s || rsv_s2_s) && (state_r == RUN);
    end
  end

  assign bus.op_s1    = op_s1_r;
  assign bus.op_s2    = op_s2_r;
  assign bus.op_valid = op_valid_r;
  assign bus.stall    = stall_s;
  assign bus.fwd_err  = fwd_err_r;

endmodule

// File: tb/tb_operand_forward.sv
// tb_operand_forward
//   Directed stimulus with a scoreboard: each drive pushes the expected stall
//   for its own cycle and, unless stalled, the expected operands for the next
//   cycle; a monitor on the falling edge pops and compares.
module tb_operand_forward;
  import operand_forward_pkg::*;

  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] s1;
    logic [DW-1:0] s2;
    logic          err;
    int            id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   done = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   drive_id = 0;
  exp_t op_q[$];
  logic stall_q[$];

  operand_forward_if #(.DW(DW)) bus ();

  operand_forward #(.DW(DW), .LOAD_OP(OP_LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs at posedge+1 and record what must follow
  task automatic drive(input logic [2:0] c1, input logic [2:0] c2,
                       input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                       input logic [DW-1:0] alu, input logic [5:0] op,
                       input logic [DW-1:0] mrd, input logic exp_stall,
                       input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                       input logic eerr);
    exp_t e;
    bus.ctrl_s1    = c1;
    bus.ctrl_s2    = c2;
    bus.rf_s1      = r1;
    bus.rf_s2      = r2;
    bus.alu_result = alu;
    bus.ex_op      = op;
    bus.mem_rdata  = mrd;
    stall_q.push_back(exp_stall);
    if (!exp_stall) begin
      e.s1  = e1;
      e.s2  = e2;
      e.err = eerr;
      e.id  = drive_id;
      op_q.push_back(e);
    end
    drive_id++;
    @(posedge clk);
    #1;
  endtask

  // Stimulus
  initial begin
    bus.ctrl_s1    = FWD_RF;
    bus.ctrl_s2    = FWD_RF;
    bus.rf_s1      = 32'd0;
    bus.rf_s2      = 32'd0;
    bus.alu_result = 32'd0;
    bus.ex_op      = OP_ADD;
    bus.mem_rdata  = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    //     c1      c2      rf1     rf2     alu         op       mrd         st    e1          e2          err
    drive(3'b000, 3'b000, 32'h11, 32'h22, 32'h0,      OP_ADD,  32'h0,      1'b0, 32'h11,     32'h22,     1'b0); // D0
    drive(3'b000, 3'b000, 32'h33, 32'h44, 32'hA5A5,   OP_ADD,  32'h0,      1'b0, 32'h33,     32'h44,     1'b0); // D1
    drive(3'b000, 3'b001, 32'h55, 32'h66, 32'h1234,   OP_ADD,  32'h0,      1'b0, 32'h55,     32'hA5A5,   1'b0); // D2
    drive(3'b000, 3'b000, 32'h1,  32'h2,  32'h5678,   OP_ADDI, 32'h0,      1'b0, 32'h1,      32'h2,      1'b0); // D3
    drive(3'b010, 3'b001, 32'h3,  32'h4,  32'h0,      OP_ADD,  32'h0,      1'b0, 32'h1234,   32'h5678,   1'b0); // D4
    drive(3'b000, 3'b000, 32'h5,  32'h6,  32'h100,    OP_LW,   32'h0,      1'b0, 32'h5,      32'h6,      1'b0); // D5
    drive(3'b001, 3'b000, 32'h7,  32'h8,  32'h0,      OP_ADD,  32'hDEAD,   1'b1, 32'h0,      32'h0,      1'b0); // D6 stall
    drive(3'b001, 3'b000, 32'h7,  32'h8,  32'h0,      OP_ADD,  32'h0,      1'b0, 32'hDEAD,   32'h8,      1'b0); // D7 hold
    drive(3'b000, 3'b101, 32'h9,  32'h77, 32'h0,      OP_ADD,  32'h0,      1'b0, 32'h9,      32'h77,     1'b1); // D8 reserved
    drive(3'b000, 3'b000, 32'hA,  32'hB,  32'hBEEF,   OP_ADD,  32'h0,      1'b0, 32'hA,      32'hB,      1'b0); // D9
    drive(3'b000, 3'b000, 32'h1,  32'h2,  32'hCAFE,   OP_ADD,  32'h0,      1'b0, 32'h1,      32'h2,      1'b0); // D10
    drive(3'b000, 3'b000, 32'h3,  32'h4,  32'h200,    OP_LW,   32'h0,      1'b0, 32'h3,      32'h4,      1'b0); // D11
    drive(3'b001, 3'b010, 32'h5,  32'h6,  32'h0,      OP_ADD,  32'hF00D,   1'b1, 32'h0,      32'h0,      1'b0); // D12 stall
    drive(3'b001, 3'b010, 32'h5,  32'h6,  32'h0,      OP_ADD,  32'h0,      1'b0, 32'hF00D,   32'hCAFE,   1'b0); // D13 hold_wb
    drive(3'b000, 3'b000, 32'h5,  32'h6,  32'h300,    OP_LW,   32'h0,      1'b0, 32'h5,      32'h6,      1'b0); // D14
    drive(3'b001, 3'b001, 32'h7,  32'h8,  32'h0,      OP_ADD,  32'h1357,   1'b1, 32'h0,      32'h0,      1'b0); // D15 stall both
    drive(3'b001, 3'b001, 32'h7,  32'h8,  32'h0,      OP_ADD,  32'h0,      1'b0, 32'h1357,   32'h1357,   1'b0); // D16 hold
    drive(3'b000, 3'b000, 32'h21, 32'h22, 32'h0,      OP_ADD,  32'h0,      1'b0, 32'h21,     32'h22,     1'b0); // D17
    drive(3'b000, 3'b000, 32'h31, 32'h32, 32'h400,    OP_LW,   32'h0,      1'b0, 32'h31,     32'h32,     1'b0); // D18
    drive(3'b001, 3'b000, 32'h7,  32'h8,  32'h0,      OP_ADD,  32'h2468,   1'b1, 32'h0,      32'h0,      1'b0); // D19 stall
    // Now in HOLD: reset without a clock edge in between
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive(3'b000, 3'b000, 32'h41, 32'h42, 32'h99,     OP_ADD,  32'h0,      1'b0, 32'h41,     32'h42,     1'b0); // D20
    drive(3'b001, 3'b000, 32'h51, 32'h52, 32'h0,      OP_ADD,  32'h0,      1'b0, 32'h99,     32'h52,     1'b0); // D21
    done = 1'b1;
  end

  // Single comparison point for the monitor
  task automatic chk(input string nm, input int id, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s[%0d] actual=%h required=%h", nm, id, act, req);
    end
  endtask

  // Monitor: compares on the falling edge, away from the active edge
  initial begin
    exp_t e;
    logic s;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_op_s1", 0, bus.op_s1, 32'd0);
        chk("rst_op_s2", 0, bus.op_s2, 32'd0);
        chk("rst_op_valid", 0, 32'(bus.op_valid), 32'd0);
        chk("rst_stall", 0, 32'(bus.stall), 32'd0);
        chk("rst_fwd_err", 0, 32'(bus.fwd_err), 32'd0);
      end else begin
        if (stall_q.size() > 0) begin
          s = stall_q.pop_front();
          chk("stall", drive_id, 32'(bus.stall), 32'(s));
        end
        if (bus.op_valid) begin
          if (op_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_op_valid actual=1 required=0 at %0t", $time);
          end else begin
            e = op_q.pop_front();
            chk("op_s1", e.id, bus.op_s1, e.s1);
            chk("op_s2", e.id, bus.op_s2, e.s2);
            chk("fwd_err", e.id, 32'(bus.fwd_err), 32'(e.err));
          end
        end else begin
          chk("fwd_err_idle", drive_id, 32'(bus.fwd_err), 32'd0);
        end
      end
      if (done) begin
        chk("op_q_left", 0, op_q.size(), 32'd0);
        chk("stall_q_left", 0, stall_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  // Bound on total run time
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "tb_operand_forward timed out");
  end

endmodule
